// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding, button
// bit positions and default timing at 100 MHz.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMING,
    HELD,
    REPEATING,
    DISARMING
  } btn_state_e;

  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_R = 2;
  localparam int BTN_U = 3;
  localparam int BTN_D = 4;

  localparam int NUM_BTN_DEF         = 5;
  localparam int DEBOUNCE_CYCLES_DEF = 2_000_000;
  localparam int HOLD_CYCLES_DEF     = 50_000_000;
  localparam int REPEAT_CYCLES_DEF   = 10_000_000;

  // One extra bit of headroom so the saturating counter can hold the largest target.
  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_if.sv
// Button bundle between the pad side (master) and the conditioner (slave).
interface btn_if #(parameter int NUM_BTN = 5);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_repeat;

  modport master (output btn_raw,
                  input  btn_level, btn_press, btn_release, btn_repeat);
  modport slave  (input  btn_raw,
                  output btn_level, btn_press, btn_release, btn_repeat);
endinterface

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce/hold/repeat FSM, saturating counters.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_T  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] HOLD_T = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_T  = CW'(REPEAT_CYCLES);

  logic          meta, sync;
  btn_state_e    state_q, state_d, ret_q, ret_d;
  logic [CW-1:0] cnt_q, cnt_d, deb_q, deb_d;
  logic [CW-1:0] cnt_inc, deb_inc, tgt;
  logic          level_d, press_d, rel_d, rpt_d;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  assign deb_inc = (&deb_q) ? deb_q : deb_q + CW'(1);
  assign tgt     = (state_q == HELD) ? HOLD_T : REP_T;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the synchroniser.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta    <= 1'b0;
      sync    <= 1'b0;
      state_q <= IDLE;
      ret_q   <= IDLE;
      cnt_q   <= '0;
      deb_q   <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
      rpt     <= 1'b0;
    end else begin
      meta    <= raw;
      sync    <= meta;
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      level   <= level_d;
      press   <= press_d;
      rel     <= rel_d;
      rpt     <= rpt_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    level_d = level;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = ARMING;
          cnt_d   = '0;
        end
      end
      ARMING: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (cnt_inc >= DEB_T) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
          rpt_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD, REPEATING: begin
        if (!sync) begin
          // The cycle just spent held still counts, but a due pulse waits for the return.
          state_d = DISARMING;
          ret_d   = state_q;
          deb_d   = '0;
          cnt_d   = (cnt_inc >= tgt) ? cnt_q : cnt_inc;
        end else if (cnt_inc >= tgt) begin
          state_d = REPEATING;
          cnt_d   = '0;
          rpt_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DISARMING: begin
        if (sync) begin
          state_d = ret_q;
        end else if (deb_inc >= DEB_T) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          deb_d = deb_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/btn_conditioner.sv
// Synchronises and debounces NUM_BTN push-buttons; one independent channel per bit.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input logic  clk,
  input logic  reset_n,
  btn_if.slave bus
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_channel (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (bus.btn_raw[i]),
      .level   (bus.btn_level[i]),
      .press   (bus.btn_press[i]),
      .rel     (bus.btn_release[i]),
      .rpt     (bus.btn_repeat[i])
    );
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input conditioning stage sitting directly upstream of the integrated task controller. It synchronises the five raw push-buttons (btnC, btnL, btnR, btnU, btnD) to clk and debounces each one. Per button it produces a clean level, a one-cycle press pulse, a release pulse and an auto-repeat pulse train. The controller consumes these instead of raw pad signals, so all P/Q/R/S tasks see single-shot, glitch-free button events.

## Interface
Parameters:
- NUM_BTN, 5, number of button channels
- DEBOUNCE_CYCLES, 2_000_000, consecutive stable cycles needed to accept a level change (20 ms at 100 MHz)
- HOLD_CYCLES, 50_000_000, cycles from press pulse to first auto-repeat pulse (500 ms)
- REPEAT_CYCLES, 10_000_000, cycles between later auto-repeat pulses (100 ms)

Ports:
- clk  in  1  100 MHz system clock; the only clock
- reset_n  in  1  synchronous, active-low reset
- btn_raw  in  NUM_BTN  asynchronous pad inputs, bit order {btnD, btnU, btnR, btnL, btnC}
- btn_level  out  NUM_BTN  debounced level
- btn_press  out  NUM_BTN  one-cycle pulse when a press is accepted
- btn_release  out  NUM_BTN  one-cycle pulse when a release is accepted
- btn_repeat  out  NUM_BTN  press pulse plus auto-repeat pulses while held

## Operation
- Each channel has a 2-flop synchroniser followed by its own FSM and one shared-width counter. Channels are fully independent.
- FSM states:
  - IDLE: sync low, level 0.
  - ARMING: sync high, counting toward DEBOUNCE_CYCLES.
  - HELD: level 1, counting toward HOLD_CYCLES.
  - REPEATING: level 1, counting toward REPEAT_CYCLES.
  - DISARMING: sync low while level 1, counting toward DEBOUNCE_CYCLES.
- Transitions:
  - IDLE→ARMING: sync=1; counter cleared.
  - ARMING→IDLE: sync=0 before the count completes (glitch rejected, no output).
  - ARMING→HELD: count reaches DEBOUNCE_CYCLES. btn_press and btn_repeat pulse; hold counter cleared.
  - HELD→REPEATING: hold count reaches HOLD_CYCLES. btn_repeat pulses; counter cleared.
  - REPEATING self-loop: every REPEAT_CYCLES, btn_repeat pulses and the counter is cleared.
  - HELD/REPEATING→DISARMING: sync=0. The hold/repeat count is saved and frozen, and a separate debounce count starts.
  - DISARMING→return state: sync=1 before DEBOUNCE_CYCLES. Go back to the saved state with the frozen count resumed; no pulse.
  - DISARMING→IDLE: count reaches DEBOUNCE_CYCLES. btn_release pulses; level 0.
- No repeat pulses are issued in DISARMING.
- Counter width is $clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES))+1. Counters saturate and never wrap.
- Reset: all states go to IDLE, synchronisers clear, counters clear, all outputs 0. A button held through reset deasserts and must be re-debounced; it produces a normal btn_press DEBOUNCE_CYCLES+2 cycles after reset_n rises.
- Simultaneous presses on different channels each produce their own pulses in the same cycle.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Press latency: btn_raw rises and stays high, first sampled at edge k. btn_level goes to 1, and btn_press and btn_repeat are high for exactly one cycle, after edge k+2+DEBOUNCE_CYCLES.
- Release latency is symmetric: btn_level goes to 0 and btn_release pulses after edge k+2+DEBOUNCE_CYCLES.
- First auto-repeat pulse comes HOLD_CYCLES cycles after the btn_press pulse. Later pulses follow at REPEAT_CYCLES spacing, excluding any cycles spent in DISARMING.
- A pulse of any kind is never wider than one cycle. btn_press and btn_release never coincide on one channel.
- Glitch rejection: a raw excursion shorter than DEBOUNCE_CYCLES sync cycles changes no output.

## Structure
- Shared package btn_pkg holds:
  - FSM state encoding (IDLE, ARMING, HELD, REPEATING, DISARMING)
  - button bit-index constants (BTN_C=0, BTN_L=1, BTN_R=2, BTN_U=3, BTN_D=4)
  - default timing constants
- Sub-module btn_channel contains the synchroniser, FSM and counter for one button. btn_conditioner instantiates it NUM_BTN times in a generate loop and only concatenates outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- Clean press: btn_raw[1] rises and is held for 8 cycles → btn_press[1] and btn_repeat[1] are one-cycle pulses, and btn_level[1]=1, 6 cycles after the rise. Other bits stay 0.
- Bounce rejection: btn_raw[0] toggles 1,0,1,0 at 1-cycle spacing and then stays 0 → all outputs remain 0 throughout.
- Auto-repeat: btn_raw[3] is held for 30 cycles → btn_repeat[3] pulses at press (cycle P), then at P+10, P+13, P+16, …; btn_press[3] pulses only once.
- Release with glitch: held button drops for 2 cycles and returns, then drops for good → no btn_release during the glitch, repeat schedule is delayed by exactly 2 cycles, and btn_release pulses 6 cycles after the final drop.
- Reset mid-hold: reset_n is driven low for 1 cycle while btn_raw[4] is held in REPEATING → outputs are 0 the cycle after reset, then btn_press[4] fires 6 cycles after reset_n rises.
- Simultaneous: btn_raw[2] and btn_raw[4] rise on the same cycle → btn_press[2] and btn_press[4] pulse in the same cycle.
